leaf_out_arbiter: RTL and testbench

- Round-robin, burst-locked arbiter that shares one leaf_interface user→interface output port between NUM_REQ user-side producer streams.
- Sits between several user cores (or several output channels of one core) and a single din_leaf_user2interface / vld_user2interface / ack_interface2user port, in the clk_user domain.
- Holds a grant for up to BURST_LEN words, then rotates priority. Drives the port from a one-entry output register.

---
 rtl/leaf_out_arbiter.sv | 144 ++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_arbiter.sv
// rtl/leaf_out_arbiter.sv - round-robin burst-locked arbiter onto one leaf_interface output port
//
// Ports:
//   clk_user                 user clock, all logic on rising edge
//   reset                    synchronous active-high reset
//   din_req                  requester data, requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   vld_req                  requester valid, one bit per requester
//   ack_req                  ack to requesters, one-hot or zero (combinational)
//   din_leaf_user2interface  data to leaf_interface, from the output register
//   vld_user2interface       valid to leaf_interface
//   ack_interface2user       ack from leaf_interface
//   grant_id                 index of current or last granted requester
//   busy                     high while a grant is held
module leaf_out_arbiter #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_REQ      = 4,
  parameter int BURST_LEN    = 16,
  parameter int REQ_BITS     = $clog2(NUM_REQ)
) (
  input  logic                            clk_user,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
  input  logic [NUM_REQ-1:0]              vld_req,
  output logic [NUM_REQ-1:0]              ack_req,
  output logic [PAYLOAD_BITS-1:0]         din_leaf_user2interface,
  output logic                            vld_user2interface,
  input  logic                            ack_interface2user,
  output logic [REQ_BITS-1:0]             grant_id,
  output logic                            busy
);

  localparam int CNT_BITS = $clog2(BURST_LEN + 1);
  localparam logic [REQ_BITS:0]   NUM_REQ_W = (REQ_BITS + 1)'(NUM_REQ);
  localparam logic [CNT_BITS-1:0] CNT_LAST  = CNT_BITS'(BURST_LEN - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]              state;
  logic [REQ_BITS-1:0]     rr_ptr;
  logic [CNT_BITS-1:0]     cnt;
  logic                    out_ready;
  logic                    xfer;
  logic                    pick_found;
  logic [REQ_BITS-1:0]     pick_idx;
  logic [REQ_BITS-1:0]     next_ptr;
  logic [REQ_BITS:0]       g_inc;
  logic [PAYLOAD_BITS-1:0] sel_data;

  assign busy      = (state == ST_GRANT);
  assign out_ready = !vld_user2interface || ack_interface2user;

  // Gated by reset so that a burst aborted by reset sees no ack in that cycle.
  assign xfer = busy && out_ready && !reset && vld_req[grant_id];

  always_comb begin
    ack_req = '0;
    if (busy && out_ready && !reset) begin
      ack_req[grant_id] = 1'b1;
    end
  end

  // Cyclic search starting at rr_ptr. Walking k downward lets the lowest
  // offset (closest to rr_ptr) be the last writer, so it wins.
  always_comb begin
    logic [REQ_BITS:0] sum;
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (REQ_BITS + 1)'(k);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      if (vld_req[sum[REQ_BITS-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = sum[REQ_BITS-1:0];
      end
    end
  end

  // Pointer after release; NUM_REQ need not be a power of two.
  assign g_inc    = {1'b0, grant_id} + (REQ_BITS + 1)'(1);
  assign next_ptr = (g_inc >= NUM_REQ_W) ? '0 : g_inc[REQ_BITS-1:0];

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == REQ_BITS'(i)) begin
        sel_data = din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            cnt      <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!vld_req[grant_id]) begin
            state  <= ST_IDLE;
            rr_ptr <= next_ptr;
            cnt    <= '0;
          end else if (xfer) begin
            if (cnt == CNT_LAST) begin
              state  <= ST_IDLE;
              rr_ptr <= next_ptr;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_BITS'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-entry output register; a load wins over the interface-side clear,
  // which gives bubble-free back-to-back words.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      vld_user2interface      <= 1'b0;
      din_leaf_user2interface <= '0;
    end else if (xfer) begin
      vld_user2interface      <= 1'b1;
      din_leaf_user2interface <= sel_data;
    end else if (vld_user2interface && ack_interface2user) begin
      vld_user2interface <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb/tb_leaf_out_arbiter.sv - self-checking bench for leaf_out_arbiter
module tb_leaf_out_arbiter;

  localparam int PB = 32;
  localparam int NR = 4;
  localparam int BL = 4;

  logic           clk_user = 1'b0;
  logic           reset;
  logic [NR*PB-1:0] din_req;
  logic [NR-1:0]  vld_req;
  logic [NR-1:0]  ack_req;
  logic [PB-1:0]  din_leaf_user2interface;
  logic           vld_user2interface;
  logic           ack_interface2user;
  logic [1:0]     grant_id;
  logic           busy;

  leaf_out_arbiter #(.PAYLOAD_BITS(PB), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .clk_user(clk_user),
    .reset(reset),
    .din_req(din_req),
    .vld_req(vld_req),
    .ack_req(ack_req),
    .din_leaf_user2interface(din_leaf_user2interface),
    .vld_user2interface(vld_user2interface),
    .ack_interface2user(ack_interface2user),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk_user = ~clk_user;

  int checks = 0;
  int errors = 0;

  // requester streams: words left in current packet, next sequence number
  int          rem [NR];
  int          seq [NR];
  int          gap [NR];
  logic [31:0] base[NR];
  bit          rnd_mode = 0;

  // reference model: who holds the grant, how many words into the burst,
  // where the next search starts, and what sits in the output register
  bit          m_busy, m_ovld, prev_busy;
  int          m_g, m_ptr, m_cnt;
  logic [31:0] m_odata;
  logic [31:0] sb[$];
  int          dut_grants[$];
  int          out_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_ovld = 0; m_odata = '0;
    sb.delete();
  endtask

  task automatic step(input bit rst_i, input bit ack_i);
    logic [NR-1:0] e_ack;
    logic [NR-1:0] v;
    logic [31:0]   w;
    bit            rdy, xfer, found;
    if (rnd_mode) begin
      for (int i = 0; i < NR; i++) begin
        if (rem[i] == 0) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            rem[i] = $urandom_range(1, 7);
            gap[i] = $urandom_range(0, 5);
          end
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      v[i] = (rem[i] > 0);
      din_req[i*PB +: PB] = base[i] + seq[i];
    end
    vld_req = v;
    reset = rst_i;
    ack_interface2user = ack_i;
    #1;
    rdy = !m_ovld || ack_i;
    e_ack = '0;
    if (m_busy && rdy && !rst_i) e_ack[m_g] = 1'b1;
    chk("ack_req", ack_req, e_ack);
    chk("vld_out", vld_user2interface, m_ovld);
    chk("din_out", din_leaf_user2interface, m_odata);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_g);
    if (busy && !prev_busy) dut_grants.push_back(int'(grant_id));
    prev_busy = busy;
    if (vld_user2interface && ack_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_order observed=%0h expected=no_word", din_leaf_user2interface);
      end else begin
        chk("sb_order", din_leaf_user2interface, sb.pop_front());
        out_cnt++;
      end
    end
    if (rst_i) begin
      model_reset();
    end else begin
      xfer = m_busy && rdy && v[m_g];
      if (m_ovld && ack_i) m_ovld = 0;
      if (xfer) begin
        w = base[m_g] + seq[m_g];
        m_odata = w;
        m_ovld = 1;
        sb.push_back(w);
        seq[m_g]++;
        rem[m_g]--;
      end
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NR; k++) begin
          if (!found && v[(m_ptr + k) % NR]) begin
            found = 1;
            m_g = (m_ptr + k) % NR;
            m_busy = 1;
            m_cnt = 0;
          end
        end
      end else if (!v[m_g]) begin
        m_busy = 0; m_ptr = (m_g + 1) % NR; m_cnt = 0;
      end else if (xfer) begin
        if (m_cnt == BL - 1) begin
          m_busy = 0; m_ptr = (m_g + 1) % NR; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk_user);
    @(negedge clk_user);
  endtask

  task automatic phase_init();
    rnd_mode = 0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; seq[i] = 0; gap[i] = 0;
      base[i] = {i[3:0], 28'h0};
    end
    step(1, 1);
    step(1, 1);
    dut_grants.delete();
    out_cnt = 0;
  endtask

  initial begin
    int total;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 100; seq[i] = 0; gap[i] = 0; base[i] = {i[3:0], 28'h0};
    end
    reset = 1; vld_req = '1; din_req = '0; ack_interface2user = 1; prev_busy = 0;
    out_cnt = 0;
    model_reset();
    @(posedge clk_user);
    @(negedge clk_user);

    // reset held with every requester valid
    repeat (3) step(1, 1);
    step(0, 1);
    chk("first_ack_after_reset", ack_req, 4'b0001);
    repeat (6) step(0, 1);

    // single requester, 10 words in bursts of 4
    phase_init();
    rem[2] = 10;
    base[2] = 32'h100;
    repeat (20) step(0, 1);
    chk("single_grant_id", grant_id, 2);
    chk("single_words", out_cnt, 10);
    chk("single_grants", dut_grants.size(), 3);

    // round robin with all requesting
    phase_init();
    for (int i = 0; i < NR; i++) rem[i] = 8;
    repeat (30) step(0, 1);
    chk("rr_g0", dut_grants[0], 0);
    chk("rr_g1", dut_grants[1], 1);
    chk("rr_g2", dut_grants[2], 2);
    chk("rr_g3", dut_grants[3], 3);
    chk("rr_g4", dut_grants[4], 0);

    // early release: 1 drops after 3 words, pointer moves to 2 so 3 beats 0
    phase_init();
    rem[1] = 3;
    rem[3] = 2;
    step(0, 1);
    step(0, 1);
    rem[0] = 2;
    repeat (15) step(0, 1);
    chk("er_g0", dut_grants[0], 1);
    chk("er_g1", dut_grants[1], 3);
    chk("er_g2", dut_grants[2], 0);
    chk("er_words", out_cnt, 7);

    // backpressure mid-burst
    phase_init();
    rem[0] = 6;
    repeat (3) step(0, 1);
    repeat (5) step(0, 0);
    repeat (12) step(0, 1);
    chk("bp_words", out_cnt, 6);

    // reset after word 2 of 4
    phase_init();
    rem[2] = 4;
    repeat (3) step(0, 1);
    step(1, 1);
    chk("rst_mid_vld", vld_user2interface, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    rem[0] = 2;
    repeat (12) step(0, 1);
    chk("rst_mid_g0", dut_grants[0], 2);
    chk("rst_mid_g1", dut_grants[1], 0);

    // randomized traffic and interface backpressure
    phase_init();
    rnd_mode = 1;
    repeat (3000) step(0, ($urandom_range(0, 3) != 0));
    rnd_mode = 0;
    repeat (80) step(0, 1);
    total = 0;
    for (int i = 0; i < NR; i++) total += seq[i];
    chk("rnd_drain", out_cnt, total);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
